// File: rtl/param_loader_pkg.sv
// Shared types and sizing for the parameter-memory loader.
package param_loader_pkg;

  typedef logic [15:0] Param_t;
  typedef logic [15:0] ParamAddr_t;

  localparam int unsigned CIM_PARAMS_BANK_SIZE_NUM_WORD = 256;
  localparam int unsigned CSUM_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StVerify,
    StDrain,
    StCheck
  } ParamLoaderState_t;

  typedef enum logic [1:0] {
    ErrNone  = 2'd0,
    ErrRange = 2'd1,
    ErrCsum  = 2'd2
  } ParamLoadErr_t;

endpackage

// File: rtl/param_loader_checksum.sv
// Modular running sum of zero-extended data words.
module param_checksum #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CSUM_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_add_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [CSUM_W-1:0] o_sum
);

  logic [CSUM_W-1:0] r_sum;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_sum <= '0;
    end else if (i_add_en) begin
      r_sum <= r_sum + CSUM_W'(i_data);
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/param_loader.sv
// Streams parameter words into the banked parameter memory and optionally
// reads the range back to confirm it against the load-time checksum.
module param_loader #(
  parameter int unsigned DATA_W     = $bits(param_loader_pkg::Param_t),
  parameter int unsigned ADDR_W     = $bits(param_loader_pkg::ParamAddr_t),
  parameter int unsigned BANK_DEPTH = param_loader_pkg::CIM_PARAMS_BANK_SIZE_NUM_WORD,
  parameter int unsigned CSUM_W     = param_loader_pkg::CSUM_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_num_words,
  input  logic              i_verify_en,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_chip_en,
  output logic              o_mem_write_en,
  output logic [ADDR_W-1:0] o_mem_write_addr,
  output logic [DATA_W-1:0] o_mem_write_data,
  output logic              o_mem_read_en,
  output logic [ADDR_W-1:0] o_mem_read_addr,
  input  logic [DATA_W-1:0] i_mem_read_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_err_code
);
  import param_loader_pkg::*;

  localparam logic [ADDR_W:0] LimitWords = (ADDR_W + 1)'(2 * BANK_DEPTH);

  ParamLoaderState_t r_state, w_state_next;
  ParamLoadErr_t     r_err, w_err_next;

  logic [ADDR_W-1:0] r_base, r_num, r_wr_cnt, r_rd_cnt;
  logic              r_verify, r_busy, r_done, r_rd_vld;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_start_ok, w_range_bad, w_in_ready, w_hs, w_load_end, w_rd_active;
  logic [ADDR_W:0]   w_end;
  logic [CSUM_W-1:0] w_load_sum, w_verify_sum;

  // Range test carries one extra bit so base+num cannot wrap past the limit.
  assign w_end       = {1'b0, i_base_addr} + {1'b0, i_num_words};
  assign w_range_bad = w_end > LimitWords;
  assign w_in_ready  = (r_state == StLoad) && (r_wr_cnt != r_num);
  assign w_hs        = i_in_valid && w_in_ready;
  assign w_load_end  = (r_state == StLoad) && (r_wr_cnt == r_num);
  assign w_rd_active = (r_state == StVerify);

  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_err;
    w_start_ok   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_start_ok = 1'b1;
          w_err_next = ErrNone;
          if (i_num_words == '0) begin
            w_state_next = StIdle;
          end else if (w_range_bad) begin
            w_err_next = ErrRange;
          end else begin
            w_state_next = StLoad;
          end
        end
      end
      StLoad: begin
        if (w_load_end) w_state_next = r_verify ? StVerify : StIdle;
      end
      StVerify: begin
        if (r_rd_cnt == r_num - ADDR_W'(1)) w_state_next = StDrain;
      end
      StDrain: w_state_next = StCheck;
      StCheck: begin
        w_state_next = StIdle;
        if (w_load_sum != w_verify_sum) w_err_next = ErrCsum;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err     <= ErrNone;
      r_base    <= '0;
      r_num     <= '0;
      r_verify  <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_err    <= w_err_next;
      r_busy   <= (w_state_next != StIdle) && (w_state_next != StCheck);
      r_done   <= (w_start_ok && (w_state_next == StIdle)) || (w_load_end && !r_verify);
      r_rd_vld <= w_rd_active;
      // Write bus idles at zero so the memory never sees stale address/data.
      r_wr_en   <= w_hs;
      r_wr_addr <= w_hs ? r_base + r_wr_cnt : '0;
      r_wr_data <= w_hs ? i_in_data : '0;
      if (w_start_ok) begin
        r_base   <= i_base_addr;
        r_num    <= i_num_words;
        r_verify <= i_verify_en;
        r_wr_cnt <= '0;
        r_rd_cnt <= '0;
      end
      if (w_hs)        r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
      if (w_rd_active) r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
    end
  end

  param_checksum #(
    .DATA_W(DATA_W),
    .CSUM_W(CSUM_W)
  ) u_load_csum (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start_ok),
    .i_add_en(w_hs),
    .i_data  (i_in_data),
    .o_sum   (w_load_sum)
  );

  param_checksum #(
    .DATA_W(DATA_W),
    .CSUM_W(CSUM_W)
  ) u_verify_csum (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start_ok),
    .i_add_en(r_rd_vld),
    .i_data  (i_mem_read_data),
    .o_sum   (w_verify_sum)
  );

  assign o_in_ready       = w_in_ready;
  assign o_busy           = r_busy;
  assign o_mem_chip_en    = r_busy;
  assign o_mem_write_en   = r_wr_en;
  assign o_mem_write_addr = r_wr_addr;
  assign o_mem_write_data = r_wr_data;
  assign o_mem_read_en    = w_rd_active;
  assign o_mem_read_addr  = w_rd_active ? r_base + r_rd_cnt : '0;
  // CHECK lasts one cycle, so its verdict is presented directly alongside done.
  assign o_done           = r_done || (r_state == StCheck);
  assign o_err_code       = (r_state == StCheck) ? w_err_next : r_err;

endmodule

// File: tb/tb_param_loader.sv
// Self-checking bench for param_loader with a behavioural memory and session model.
module tb_param_loader;
  import param_loader_pkg::*;

  localparam int BD  = CIM_PARAMS_BANK_SIZE_NUM_WORD;
  localparam int TOT = 2 * BD;
  localparam int AW  = $clog2(TOT);

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, verify_en = 1'b0, in_valid = 1'b0;
  logic [15:0] base_addr = '0, num_words = '0, in_data = '0, rd_data = '0;
  logic        in_ready, chip_en, wr_en, rd_en, busy, done;
  logic [15:0] wr_addr, wr_data, rd_addr;
  logic [1:0]  err;

  typedef struct {int cyc; int a; int d;} ev_t;
  ev_t wr_q[$], rd_q[$], dn_q[$];
  ev_t mon_e;
  int  cyc = 0, viol = 0, n_checks = 0, n_fail = 0;
  bit  mon_en = 1'b0, corrupt = 1'b0;
  logic [15:0] mem [0:TOT-1];
  logic [15:0] word_tbl [0:63];
  bit  busy_hist [0:4095];

  param_loader dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
    .i_num_words(num_words), .i_verify_en(verify_en), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_in_ready(in_ready), .o_mem_chip_en(chip_en),
    .o_mem_write_en(wr_en), .o_mem_write_addr(wr_addr), .o_mem_write_data(wr_data),
    .o_mem_read_en(rd_en), .o_mem_read_addr(rd_addr), .i_mem_read_data(rd_data),
    .o_busy(busy), .o_done(done), .o_err_code(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: 1-cycle read latency, optional corruption of the word at BD.
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr[AW-1:0]] <= wr_data;
    rd_data <= (corrupt && int'(rd_addr) == BD) ? 16'h0000 : mem[rd_addr[AW-1:0]];
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_en) begin
        mon_e.cyc = cyc; mon_e.a = int'(wr_addr); mon_e.d = int'(wr_data); wr_q.push_back(mon_e);
      end
      if (rd_en) begin
        mon_e.cyc = cyc; mon_e.a = int'(rd_addr); mon_e.d = 0; rd_q.push_back(mon_e);
      end
      if (done) begin
        mon_e.cyc = cyc; mon_e.a = int'(err); mon_e.d = 0; dn_q.push_back(mon_e);
      end
      if (wr_en && rd_en) viol++;
      if (chip_en !== busy) viol++;
      if (!wr_en && (wr_addr != 16'h0 || wr_data != 16'h0)) viol++;
      if (cyc < 4096) busy_hist[cyc] = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete session: drives start and the ingress stream, predicts the
  // memory traffic and completion from the address/timing rules, then compares.
  task automatic run_session(input string nm, input int base, input int num, input bit ver,
                             input bit corr, input int vmode, input bit restart,
                             input int abort_rd);
    int s, acc, t_last, step, exp_done, exp_err, exp_rd, guard;
    logic [31:0] sum_w, sum_r;
    bit v, immediate;
    ev_t exp_w[$];
    ev_t e;
    wr_q.delete(); rd_q.delete(); dn_q.delete();
    viol = 0; corrupt = corr;
    immediate = (num == 0) || (base + num > TOT);
    exp_rd = 0; exp_err = 0; t_last = 0; exp_done = -1;
    tick();
    s = cyc;
    start = 1'b1; base_addr = 16'(base); num_words = 16'(num); verify_en = ver;
    tick();
    start = 1'b0; base_addr = 16'($urandom); num_words = 16'($urandom); verify_en = ~ver;
    if (immediate) begin
      exp_done = s + 1;
      exp_err  = (num == 0) ? 0 : 1;
    end else begin
      acc = 0; step = 0;
      while (acc < num && step < 400) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL %s in_ready_load cyc=%0d got=%b want=1", nm, cyc, in_ready);
        end
        case (vmode)
          0:       v = 1'b1;
          1:       v = (step % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        in_valid = v;
        in_data  = v ? word_tbl[acc] : 16'($urandom);
        if (restart && step == 1) begin
          start = 1'b1; base_addr = 16'(base + 7); num_words = 16'd1;
        end
        if (v) begin
          e.cyc = cyc + 1; e.a = base + acc; e.d = int'(word_tbl[acc]);
          exp_w.push_back(e);
          t_last = cyc;
          acc++;
        end
        step++;
        tick();
        start = 1'b0; in_valid = 1'b0;
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s in_ready_after_last cyc=%0d got=%b want=0", nm, cyc, in_ready);
      end
      if (ver) begin
        exp_rd   = num;
        exp_done = t_last + 3 + num;
        sum_w = '0; sum_r = '0;
        for (int k = 0; k < num; k++) begin
          sum_w += 32'(word_tbl[k]);
          sum_r += (corr && base + k == BD) ? 32'h0 : 32'(word_tbl[k]);
        end
        exp_err = (sum_w != sum_r) ? 2 : 0;
      end else begin
        exp_done = t_last + 2;
      end
      if (abort_rd > 0) begin
        repeat (abort_rd) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, chip_en, wr_en, rd_en, done, err} !== 7'b0) begin
          n_fail++;
          $display("FAIL %s abort_outputs got busy=%b ce=%b we=%b re=%b done=%b err=%0d want all 0",
                   nm, busy, chip_en, wr_en, rd_en, done, err);
        end
        exp_rd = abort_rd; exp_done = -1; exp_err = 0;
      end
    end
    guard = 0;
    while (exp_done >= 0 && dn_q.size() == 0 && guard < 200) begin
      tick();
      guard++;
    end
    repeat (4) tick();

    n_checks++;
    if (dn_q.size() != ((exp_done >= 0) ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s done_count got=%0d want=%0d", nm, dn_q.size(), (exp_done >= 0) ? 1 : 0);
    end
    if (exp_done >= 0 && dn_q.size() > 0) begin
      n_checks++;
      if (dn_q[0].cyc != exp_done || dn_q[0].a != exp_err) begin
        n_fail++;
        $display("FAIL %s done_pulse got cyc=%0d err=%0d want cyc=%0d err=%0d",
                 nm, dn_q[0].cyc, dn_q[0].a, exp_done, exp_err);
      end
    end
    n_checks++;
    if (err !== 2'(exp_err)) begin
      n_fail++;
      $display("FAIL %s err_held got=%0d want=%0d", nm, err, exp_err);
    end
    n_checks++;
    if (wr_q.size() != exp_w.size()) begin
      n_fail++;
      $display("FAIL %s write_count got=%0d want=%0d", nm, wr_q.size(), exp_w.size());
    end
    for (int k = 0; k < exp_w.size() && k < wr_q.size(); k++) begin
      n_checks++;
      if (wr_q[k].cyc != exp_w[k].cyc || wr_q[k].a != exp_w[k].a || wr_q[k].d != exp_w[k].d) begin
        n_fail++;
        $display("FAIL %s write[%0d] got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                 nm, k, wr_q[k].cyc, wr_q[k].a, wr_q[k].d, exp_w[k].cyc, exp_w[k].a, exp_w[k].d);
      end
    end
    n_checks++;
    if (rd_q.size() != exp_rd) begin
      n_fail++;
      $display("FAIL %s read_count got=%0d want=%0d", nm, rd_q.size(), exp_rd);
    end
    for (int k = 0; k < exp_rd && k < rd_q.size(); k++) begin
      n_checks++;
      if (rd_q[k].cyc != t_last + 2 + k || rd_q[k].a != base + k) begin
        n_fail++;
        $display("FAIL %s read[%0d] got cyc=%0d addr=%0d want cyc=%0d addr=%0d",
                 nm, k, rd_q[k].cyc, rd_q[k].a, t_last + 2 + k, base + k);
      end
    end
    if (!immediate && abort_rd == 0) begin
      n_checks++;
      if (!busy_hist[s + 1] || !busy_hist[exp_done - 1] || busy_hist[exp_done]) begin
        n_fail++;
        $display("FAIL %s busy_window got start+1=%b done-1=%b done=%b want 1 1 0",
                 nm, busy_hist[s + 1], busy_hist[exp_done - 1], busy_hist[exp_done]);
      end
    end
    n_checks++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL %s bus_invariants got=%0d violations want=0", nm, viol);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 64; k++) word_tbl[k] = 16'($urandom_range(1, 65535));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({in_ready, chip_en, wr_en, rd_en, busy, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy=%b ce=%b we=%b re=%b busy=%b done=%b want 0",
               in_ready, chip_en, wr_en, rd_en, busy, done);
    end
    n_checks++;
    if ({wr_addr, wr_data, rd_addr} !== 48'h0 || err !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_bus got wa=%h wd=%h ra=%h err=%0d want 0", wr_addr, wr_data, rd_addr, err);
    end
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    n_checks++;
    if ({in_ready, busy, done} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_release got rdy=%b busy=%b done=%b want 0", in_ready, busy, done);
    end
  endtask

  task automatic test_load_only();
    word_tbl[0] = 16'h0001; word_tbl[1] = 16'h0002;
    word_tbl[2] = 16'h0003; word_tbl[3] = 16'hFFFF;
    run_session("load_only", 0, 4, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_bank_cross();
    fill_random();
    run_session("bank_cross", BD - 2, 4, 1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_csum_fault();
    fill_random();
    run_session("csum_fault", BD - 2, 4, 1'b1, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_range_empty();
    run_session("range", TOT - 1, 2, 1'b1, 1'b0, 0, 1'b0, 0);
    run_session("empty", 5, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    run_session("range_exact_ok", TOT - 3, 3, 1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_backpressure_restart();
    fill_random();
    run_session("backpressure", 10, 2, 1'b0, 1'b0, 1, 1'b1, 0);
  endtask

  task automatic test_reset_mid_verify();
    fill_random();
    run_session("abort_verify", 40, 4, 1'b1, 1'b0, 0, 1'b0, 2);
    fill_random();
    run_session("after_abort", 40, 4, 1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    int b, n;
    for (int i = 0; i < 8; i++) begin
      fill_random();
      b = (i % 2 == 0) ? BD - int'($urandom_range(0, 6)) : int'($urandom_range(0, TOT - 1));
      n = int'($urandom_range(0, 12));
      run_session("random", b, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_load_only();
    test_bank_cross();
    test_csum_fault();
    test_range_empty();
    test_backpressure_restart();
    test_reset_mid_verify();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
